ram_sdp_init: RTL

//   Simple dual-port synchronous RAM: one write port, one read port, one clock.

---
 rtl/ram_sdp_init_pkg.sv | 28 ++
 rtl/ram_sdp_init_if.sv | 29 ++
 rtl/ram_sdp_clear_fsm.sv | 59 +++++
 rtl/ram_sdp_init.sv | 116 +++++++++++
 4 files changed

// File: rtl/ram_sdp_init_pkg.sv
// rtl/ram_sdp_init_pkg.sv - shared state type and lane-merge helper for ram_sdp_init
package ram_sdp_pkg;

  typedef enum logic [0:0] {ST_CLEAR, ST_READY} ram_state_t;

  localparam int MERGE_DW    = 512;
  localparam int MERGE_LANES = 64;

  // Builds a bit mask from the lane enables with shifts so any lane width works.
  function automatic logic [MERGE_DW-1:0] lane_merge(
    input logic [MERGE_DW-1:0]    old_word,
    input logic [MERGE_DW-1:0]    new_word,
    input logic [MERGE_LANES-1:0] be,
    input int                     lane_width
  );
    logic [MERGE_DW-1:0] lane_ones;
    logic [MERGE_DW-1:0] mask;
    lane_ones = ~({MERGE_DW{1'b1}} << lane_width);
    mask      = '0;
    for (int l = 0; l < MERGE_LANES; l++) begin
      if (|(be & (MERGE_LANES'(1) << l))) begin
        mask = mask | (lane_ones << (l * lane_width));
      end
    end
    return (new_word & mask) | (old_word & ~mask);
  endfunction

endpackage

// File: rtl/ram_sdp_init_if.sv
// rtl/ram_sdp_init_if.sv - access/clear bus of ram_sdp_init
interface ram_sdp_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int ADDRSIZE   = 4
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  clear_req;
  logic                  wr_en;
  logic [ADDRSIZE-1:0]   wr_addr;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDRSIZE-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;

  modport master (
    output clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_done
  );
endinterface

// File: rtl/ram_sdp_clear_fsm.sv
// rtl/ram_sdp_clear_fsm.sv - clear sequencer: walks every word after reset or clear request
module ram_sdp_clear_fsm
  import ram_sdp_pkg::*;
#(
  parameter int MAX_ADDR = 16,
  parameter int ADDRSIZE = $clog2(MAX_ADDR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear_req,
  output logic                o_clr_we,
  output logic [ADDRSIZE-1:0] o_clr_addr,
  output logic                o_init_done
);

  localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);

  ram_state_t          r_state;
  ram_state_t          w_state_nxt;
  logic [ADDRSIZE-1:0] r_cnt;
  logic [ADDRSIZE-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (i_clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign o_clr_we    = (r_state == ST_CLEAR);
  assign o_clr_addr  = r_cnt;
  assign o_init_done = (r_state == ST_READY);

endmodule

// File: rtl/ram_sdp_init.sv
// rtl/ram_sdp_init.sv - simple dual-port RAM with lane enables, write-first bypass, hardware clear
// Optional RAM_SDP_OUT_REG_EN adds a second output register stage (read latency 2).
module ram_sdp_init
  import ram_sdp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int MAX_ADDR   = 16,
  parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_sdp_init_if.slave  bus
);

  localparam int                LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDRSIZE:0] DEPTH = (ADDRSIZE + 1)'(MAX_ADDR);

  logic                  w_init_done;
  logic                  w_clr_we;
  logic [ADDRSIZE-1:0]   w_clr_addr;

  ram_sdp_clear_fsm #(
    .MAX_ADDR (MAX_ADDR),
    .ADDRSIZE (ADDRSIZE)
  ) u_clear_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear_req (bus.clear_req),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr),
    .o_init_done (w_init_done)
  );

  logic [DATA_WIDTH-1:0] r_mem [MAX_ADDR];

  logic                  w_port_ok;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rd_in_range;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // A clear request wins the cycle: accesses presented alongside it are dropped.
  assign w_port_ok     = w_init_done & ~bus.clear_req;
  assign w_wr_acc      = w_port_ok & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH);
  assign w_rd_acc      = w_port_ok & bus.rd_en;
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < DEPTH);
  assign w_rd_old      = r_mem[bus.rd_addr];
  assign w_collide     = w_wr_acc & (bus.rd_addr == bus.wr_addr);

  assign w_wr_merged = DATA_WIDTH'(lane_merge(MERGE_DW'(r_mem[bus.wr_addr]),
                                              MERGE_DW'(bus.wr_data),
                                              MERGE_LANES'(bus.wr_be),
                                              LANE_WIDTH));

  // On a collision both ports hit the same word, so the merged write word is the bypass value.
  assign w_rd_word = !w_rd_in_range ? '0 :
                     w_collide      ? w_wr_merged : w_rd_old;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.wr_addr] <= w_wr_merged;
    end
  end

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

`ifdef RAM_SDP_OUT_REG_EN
  logic                  w_clr_start;
  logic                  w_s2_load;
  logic [DATA_WIDTH-1:0] r_rd_data2;
  logic                  r_rd_valid2;

  assign w_clr_start = w_init_done & bus.clear_req;
  assign w_s2_load   = r_rd_valid & ~w_clr_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data2  <= '0;
      r_rd_valid2 <= 1'b0;
    end else begin
      r_rd_valid2 <= w_s2_load;
      if (w_s2_load) begin
        r_rd_data2 <= r_rd_data;
      end
    end
  end

  assign bus.rd_data  = r_rd_data2;
  assign bus.rd_valid = r_rd_valid2;
`else
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
`endif

  assign bus.init_done = w_init_done;

endmodule
